regfile_dump_reader: RTL

Debug read-out engine that sits on a spare read port of the register file and serially reads every register, 0 to N_REGS-1. It presents each value, tagged with its address, on a valid/ready stream to the debug/trace logic. It is the read-side counterpart of the register-file write path. It never writes registers and does not stall the pipeline.

---
 rtl/regfile_dump_reader.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: serially reads every register through a spare
// read port and streams {addr, data} beats out on a valid/ready link.
module regfile_dump_reader #(
  parameter int N_BITS    = 32,
  parameter int ADDR_BITS = 5,
  parameter int N_REGS    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic [ADDR_BITS-1:0] rd_addr_o,
  input  logic [N_BITS-1:0]    rd_data_i,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [N_BITS-1:0]    dump_data_o,
  output logic [ADDR_BITS-1:0] dump_addr_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(N_REGS - 1);

  state_t               state_q;
  logic [ADDR_BITS-1:0] addr_q;

  // Read port always follows the walk counter; data is combinational.
  assign rd_addr_o = addr_q;

  // Dump sequencer; status outputs are registered with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      busy_o       <= 1'b0;
      dump_valid_o <= 1'b0;
      dump_data_o  <= '0;
      dump_addr_o  <= '0;
      done_o       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q  <= '0;
            busy_o  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (abort_i) begin
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else begin
            dump_data_o  <= rd_data_i;
            dump_addr_o  <= addr_q;
            dump_valid_o <= 1'b1;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (abort_i) begin
            dump_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            state_q      <= IDLE;
          end else if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            if (addr_q == LAST) begin
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_q + ADDR_BITS'(1);
              state_q <= READ;
            end
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          dump_valid_o <= 1'b0;
          done_o       <= 1'b0;
          busy_o       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule
